// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver.
// Glyph patterns are a..g with bit 0 = segment a.
package seg7_pkg;

    localparam int N_DIGITS = 4;

    localparam logic [6:0] GLYPH_0     = 7'h3F;
    localparam logic [6:0] GLYPH_1     = 7'h06;
    localparam logic [6:0] GLYPH_2     = 7'h5B;
    localparam logic [6:0] GLYPH_3     = 7'h4F;
    localparam logic [6:0] GLYPH_4     = 7'h66;
    localparam logic [6:0] GLYPH_5     = 7'h6D;
    localparam logic [6:0] GLYPH_6     = 7'h7D;
    localparam logic [6:0] GLYPH_7     = 7'h07;
    localparam logic [6:0] GLYPH_8     = 7'h7F;
    localparam logic [6:0] GLYPH_9     = 7'h6F;
    localparam logic [6:0] GLYPH_DASH  = 7'h40;
    localparam logic [6:0] GLYPH_BLANK = 7'h00;

endpackage

// File: rtl/seg7_glyph.sv
// Combinational BCD nibble to 7-segment decoder.
// Non-decimal nibbles render as a dash.
module seg7_glyph
    import seg7_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    // Map each nibble to its segment pattern
    always_comb begin
        seg_o = GLYPH_DASH;
        case (nib_i)
            4'd0:    seg_o = GLYPH_0;
            4'd1:    seg_o = GLYPH_1;
            4'd2:    seg_o = GLYPH_2;
            4'd3:    seg_o = GLYPH_3;
            4'd4:    seg_o = GLYPH_4;
            4'd5:    seg_o = GLYPH_5;
            4'd6:    seg_o = GLYPH_6;
            4'd7:    seg_o = GLYPH_7;
            4'd8:    seg_o = GLYPH_8;
            4'd9:    seg_o = GLYPH_9;
            default: seg_o = GLYPH_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit 7-segment driver.
// Loads are double-buffered and only take effect on frame boundaries.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIV     = 16,
    parameter int GAP     = 2,
    parameter bit SEG_INV = 1'b0,
    parameter bit SEL_INV = 1'b0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        load_i,
    input  logic [15:0] value_i,
    input  logic [3:0]  dp_i,
    input  logic        lz_blank_i,
    output logic [6:0]  seg_o,
    output logic        dp_o,
    output logic [3:0]  sel_o,
    output logic        frame_o
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] r_div_cnt;
    logic [1:0]    r_idx;

    logic [15:0]   r_act_val;
    logic [3:0]    r_act_dp;
    logic          r_act_lz;
    logic [15:0]   r_pnd_val;
    logic [3:0]    r_pnd_dp;
    logic          r_pnd_lz;
    logic          r_pnd_ok;

    logic [6:0]    r_seg;
    logic          r_dp;
    logic [3:0]    r_sel;
    logic          r_frame;

    logic          w_slot_end;
    logic          w_boundary;
    logic [3:0]    w_zero;
    logic [3:0]    w_blank;
    logic [3:0]    w_nib;
    logic [6:0]    w_glyph;
    logic [6:0]    w_seg;
    logic [3:0]    w_sel;

    assign w_slot_end = (r_div_cnt == CW'(DIV - 1));
    assign w_boundary = w_slot_end && (r_idx == 2'(N_DIGITS - 1));

    assign w_zero[0] = (r_act_val[3:0]   == 4'd0);
    assign w_zero[1] = (r_act_val[7:4]   == 4'd0);
    assign w_zero[2] = (r_act_val[11:8]  == 4'd0);
    assign w_zero[3] = (r_act_val[15:12] == 4'd0);

    // A digit blanks only when it and every digit above it are zero
    assign w_blank[3] = r_act_lz & w_zero[3];
    assign w_blank[2] = w_blank[3] & w_zero[2];
    assign w_blank[1] = w_blank[2] & w_zero[1];
    assign w_blank[0] = 1'b0;

    assign w_nib = r_act_val[{r_idx, 2'b00} +: 4];

    seg7_glyph u_glyph (
        .nib_i (w_nib),
        .seg_o (w_glyph)
    );

    assign w_seg = w_blank[r_idx] ? GLYPH_BLANK : w_glyph;
    assign w_sel = (r_div_cnt < CW'(GAP)) ? 4'b0000 : (4'b0001 << r_idx);

    // Slot counter and digit index rotation
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_div_cnt <= '0;
            r_idx     <= 2'd0;
        end else if (w_slot_end) begin
            r_div_cnt <= '0;
            r_idx     <= r_idx + 2'd1;
        end else begin
            r_div_cnt <= r_div_cnt + CW'(1);
        end
    end

    // Pending/active double buffer; swap only at the frame boundary
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_act_val <= '0;
            r_act_dp  <= '0;
            r_act_lz  <= 1'b0;
            r_pnd_val <= '0;
            r_pnd_dp  <= '0;
            r_pnd_lz  <= 1'b0;
            r_pnd_ok  <= 1'b0;
        end else if (w_boundary) begin
            if (load_i) begin
                r_act_val <= value_i;
                r_act_dp  <= dp_i;
                r_act_lz  <= lz_blank_i;
            end else if (r_pnd_ok) begin
                r_act_val <= r_pnd_val;
                r_act_dp  <= r_pnd_dp;
                r_act_lz  <= r_pnd_lz;
            end
            r_pnd_ok <= 1'b0;
        end else if (load_i) begin
            r_pnd_val <= value_i;
            r_pnd_dp  <= dp_i;
            r_pnd_lz  <= lz_blank_i;
            r_pnd_ok  <= 1'b1;
        end
    end

    // Registered pins with polarity applied at the flop inputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_seg   <= {7{SEG_INV}};
            r_dp    <= SEG_INV;
            r_sel   <= {4{SEL_INV}};
            r_frame <= 1'b0;
        end else begin
            r_seg   <= w_seg ^ {7{SEG_INV}};
            r_dp    <= r_act_dp[r_idx] ^ SEG_INV;
            r_sel   <= w_sel ^ {4{SEL_INV}};
            r_frame <= (r_idx == 2'd0) && (r_div_cnt == '0);
        end
    end

    assign seg_o   = r_seg;
    assign dp_o    = r_dp;
    assign sel_o   = r_sel;
    assign frame_o = r_frame;

endmodule
